time_set_controller: RTL and testbench

- Mode/adjust sequencer for the alarm clock's modulo up/down counter chain (seconds, minutes, hours, alarm minutes, alarm hours).
- Takes debounced single-cycle button pulses and the 1 Hz tick.
- Generates the counter enable, up/down and load controls, so the counters never see raw buttons.
- Sits between the button conditioning logic and the counter datapath.

---
 rtl/clock_pkg.sv | 45 ++++
 rtl/inactivity_timer.sv | 31 +++
 rtl/time_set_controller.sv | 101 ++++++++++
 tb/tb_time_set_controller.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared encodings for the alarm clock's mode sequencer and counter chain.
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN       = 2'd0,
    MODE_SET_TIME  = 2'd1,
    MODE_SET_ALARM = 2'd2
  } mode_t;

  typedef enum logic {
    FIELD_MIN  = 1'b0,
    FIELD_HOUR = 1'b1
  } field_t;

  localparam int ADJ_TIME_MIN   = 0;
  localparam int ADJ_TIME_HOUR  = 1;
  localparam int ADJ_ALARM_MIN  = 2;
  localparam int ADJ_ALARM_HOUR = 3;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  function automatic mode_t nextMode(input mode_t cur);
    case (cur)
      MODE_RUN:      nextMode = MODE_SET_TIME;
      MODE_SET_TIME: nextMode = MODE_SET_ALARM;
      default:       nextMode = MODE_RUN;
    endcase
  endfunction

  // One-hot adjust enable for the counter owned by this mode/field pair.
  function automatic logic [3:0] adjBit(input mode_t cur, input field_t fld);
    logic [3:0] onehot;
    onehot = '0;
    if (cur == MODE_SET_ALARM) begin
      if (fld == FIELD_HOUR) onehot[ADJ_ALARM_HOUR] = 1'b1;
      else                   onehot[ADJ_ALARM_MIN]  = 1'b1;
    end else begin
      if (fld == FIELD_HOUR) onehot[ADJ_TIME_HOUR] = 1'b1;
      else                   onehot[ADJ_TIME_MIN]  = 1'b1;
    end
    adjBit = onehot;
  endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Counts 1 Hz ticks while enabled; expire stays high from the cycle the count
// reaches TIMEOUT_S until cleared. TIMEOUT_S = 0 makes the timer inert.
module inactivity_timer #(
  parameter int TIMEOUT_S = 30,
  parameter int TO_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic clear,
  input  logic tick,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT_S);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && tick && (TIMEOUT_S != 0) && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (TIMEOUT_S != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/time_set_controller.sv
// Mode/adjust sequencer driving the clock's counter chain from debounced buttons.
// Define TIME_SET_BLINK_EN to build the 0.5 Hz blink phase for the selected field.
module time_set_controller
  import clock_pkg::*;
#(
  parameter int TIMEOUT_S = 30,
  parameter int TO_W      = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_next,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [1:0] mode,
  output logic       sec_en,
  output logic       sec_ld,
  output logic [3:0] adj_en,
  output logic       adj_updown,
  output logic       field,
  output logic       blink
);

  mode_t  modeQ;
  field_t fieldQ;
  logic   anyBtn;
  logic   inSet;
  logic   expire;
  logic   timeoutFire;
  logic   modeChange;
  logic   adjustReq;

  assign anyBtn      = btn_mode | btn_next | btn_up | btn_down;
  assign inSet       = (modeQ != MODE_RUN);
  assign timeoutFire = expire & ~anyBtn;
  assign modeChange  = btn_mode | timeoutFire;
  assign adjustReq   = inSet & ~btn_mode & (btn_up ^ btn_down);

  inactivity_timer #(
    .TIMEOUT_S(TIMEOUT_S),
    .TO_W     (TO_W)
  ) u_timer (
    .clk   (clk),
    .rst   (rst),
    .enable(inSet),
    .clear (anyBtn | modeChange | ~inSet),
    .tick  (tick_1hz),
    .expire(expire)
  );

  // btn_mode outranks every other button; a timeout only acts on a quiet cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      modeQ      <= MODE_RUN;
      fieldQ     <= FIELD_MIN;
      sec_en     <= 1'b0;
      sec_ld     <= 1'b0;
      adj_en     <= '0;
      adj_updown <= DIR_UP;
    end else begin
      sec_en <= tick_1hz & (modeQ != MODE_SET_TIME);
      sec_ld <= 1'b0;
      adj_en <= '0;
      if (modeChange) begin
        modeQ  <= btn_mode ? nextMode(modeQ) : MODE_RUN;
        fieldQ <= FIELD_MIN;
        sec_ld <= (modeQ == MODE_SET_TIME);
      end else if (inSet) begin
        if (btn_next) fieldQ <= (fieldQ == FIELD_MIN) ? FIELD_HOUR : FIELD_MIN;
        if (adjustReq) begin
          adj_en     <= adjBit(modeQ, fieldQ);
          adj_updown <= btn_down ? DIR_DOWN : DIR_UP;
        end
      end
    end
  end

  assign mode  = modeQ;
  assign field = fieldQ;

`ifdef TIME_SET_BLINK_EN
  logic phase;

  // Phase is solid right after entry or an adjustment, then flips every tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase <= 1'b0;
    end else if (modeChange || adjustReq) begin
      phase <= 1'b0;
    end else if (inSet && tick_1hz) begin
      phase <= ~phase;
    end
  end

  assign blink = phase;
`else
  assign blink = 1'b0;
`endif

endmodule

// File: tb/tb_time_set_controller.sv
// Directed-vector bench for time_set_controller built with a 3 s timeout.
module tb_time_set_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_1hz, btn_mode, btn_next, btn_up, btn_down;
  logic [1:0] mode;
  logic       sec_en, sec_ld, adj_updown, field, blink;
  logic [3:0] adj_en;

  int vectors = 0;
  int errors  = 0;

  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] TICK = 5'b00001;
  localparam logic [4:0] DOWN = 5'b00010;
  localparam logic [4:0] UP   = 5'b00100;
  localparam logic [4:0] NEXT = 5'b01000;
  localparam logic [4:0] MODE = 5'b10000;

`ifdef TIME_SET_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  time_set_controller #(.TIMEOUT_S(3), .TO_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .btn_mode  (btn_mode),
    .btn_next  (btn_next),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .mode      (mode),
    .sec_en    (sec_en),
    .sec_ld    (sec_ld),
    .adj_en    (adj_en),
    .adj_updown(adj_updown),
    .field     (field),
    .blink     (blink)
  );

  always #5 clk = ~clk;

  // Drives one cycle of {mode,next,up,down,tick}; returns at the next falling
  // edge, where the registered response to that cycle is visible.
  task automatic applyStimulus(input logic [4:0] v);
    {btn_mode, btn_next, btn_up, btn_down, tick_1hz} = v;
    @(negedge clk);
    {btn_mode, btn_next, btn_up, btn_down, tick_1hz} = 5'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    vectors++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  initial begin
    rst = 1'b1;
    {btn_mode, btn_next, btn_up, btn_down, tick_1hz} = 5'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mode", 8'(mode), 8'd0);
    checkOutput("rst_field", 8'(field), 8'd0);
    checkOutput("rst_sec_en", 8'(sec_en), 8'd0);
    checkOutput("rst_sec_ld", 8'(sec_ld), 8'd0);
    checkOutput("rst_adj_en", 8'(adj_en), 8'd0);
    checkOutput("rst_updown", 8'(adj_updown), 8'd0);
    checkOutput("rst_blink", 8'(blink), 8'd0);

    applyStimulus(TICK);
    checkOutput("run_tick_sec_en", 8'(sec_en), 8'd1);
    applyStimulus(IDLE);
    checkOutput("run_idle_sec_en", 8'(sec_en), 8'd0);

    // Set time: three ups on minutes, then one down on hours
    applyStimulus(MODE);
    checkOutput("st_mode", 8'(mode), 8'd1);
    checkOutput("st_sec_ld", 8'(sec_ld), 8'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(UP);
      checkOutput("st_up_adj", 8'(adj_en), 8'b0001);
      checkOutput("st_up_dir", 8'(adj_updown), 8'd0);
    end
    applyStimulus(TICK);
    checkOutput("st_tick_sec_en", 8'(sec_en), 8'd0);
    checkOutput("st_tick_blink", 8'(blink), 8'(BLINK_ON));
    applyStimulus(NEXT);
    checkOutput("st_next_field", 8'(field), 8'd1);
    checkOutput("st_next_adj", 8'(adj_en), 8'd0);
    applyStimulus(DOWN);
    checkOutput("st_down_adj", 8'(adj_en), 8'b0010);
    checkOutput("st_down_dir", 8'(adj_updown), 8'd1);
    checkOutput("st_down_blink", 8'(blink), 8'd0);
    applyStimulus(IDLE);
    checkOutput("st_idle_adj", 8'(adj_en), 8'd0);
    checkOutput("st_hold_dir", 8'(adj_updown), 8'd1);
    applyStimulus(UP | DOWN);
    checkOutput("st_updown_adj", 8'(adj_en), 8'd0);

    // Leave SET_TIME into SET_ALARM
    applyStimulus(MODE);
    checkOutput("sa_mode", 8'(mode), 8'd2);
    checkOutput("sa_sec_ld", 8'(sec_ld), 8'd1);
    checkOutput("sa_field", 8'(field), 8'd0);
    applyStimulus(IDLE);
    checkOutput("sa_sec_ld_once", 8'(sec_ld), 8'd0);
    applyStimulus(UP);
    checkOutput("sa_up_adj", 8'(adj_en), 8'b0100);
    checkOutput("sa_up_dir", 8'(adj_updown), 8'd0);
    applyStimulus(NEXT);
    applyStimulus(DOWN);
    checkOutput("sa_down_adj", 8'(adj_en), 8'b1000);
    checkOutput("sa_down_dir", 8'(adj_updown), 8'd1);
    applyStimulus(TICK);
    checkOutput("sa_tick_sec_en", 8'(sec_en), 8'd1);
    applyStimulus(MODE | UP);
    checkOutput("sa_modeup_mode", 8'(mode), 8'd0);
    checkOutput("sa_modeup_adj", 8'(adj_en), 8'd0);
    checkOutput("sa_modeup_field", 8'(field), 8'd0);
    checkOutput("sa_exit_sec_ld", 8'(sec_ld), 8'd0);

    // RUN ignores field and adjust buttons
    applyStimulus(NEXT);
    checkOutput("run_next_field", 8'(field), 8'd0);
    applyStimulus(UP);
    checkOutput("run_up_adj", 8'(adj_en), 8'd0);

    // Timeout out of SET_TIME after three quiet ticks
    applyStimulus(MODE);
    applyStimulus(TICK);
    checkOutput("to_blink1", 8'(blink), 8'(BLINK_ON));
    applyStimulus(TICK);
    checkOutput("to_blink2", 8'(blink), 8'd0);
    applyStimulus(TICK);
    checkOutput("to_pre_mode", 8'(mode), 8'd1);
    applyStimulus(IDLE);
    checkOutput("to_mode", 8'(mode), 8'd0);
    checkOutput("to_sec_ld", 8'(sec_ld), 8'd1);
    checkOutput("to_blink_run", 8'(blink), 8'd0);
    applyStimulus(IDLE);
    checkOutput("to_sec_ld_once", 8'(sec_ld), 8'd0);

    // An adjustment restarts the inactivity window
    applyStimulus(MODE);
    applyStimulus(TICK);
    applyStimulus(TICK);
    applyStimulus(UP);
    checkOutput("tr_up_adj", 8'(adj_en), 8'b0001);
    applyStimulus(TICK);
    applyStimulus(IDLE);
    checkOutput("tr_still_set", 8'(mode), 8'd1);
    applyStimulus(TICK);
    applyStimulus(TICK);
    applyStimulus(IDLE);
    checkOutput("tr_late_mode", 8'(mode), 8'd0);
    checkOutput("tr_late_sec_ld", 8'(sec_ld), 8'd1);

    // Timeout from SET_ALARM returns to RUN without a seconds load
    applyStimulus(MODE);
    applyStimulus(MODE);
    repeat (3) applyStimulus(TICK);
    applyStimulus(IDLE);
    checkOutput("ta_mode", 8'(mode), 8'd0);
    checkOutput("ta_sec_ld", 8'(sec_ld), 8'd0);

    // A button in the expiry cycle beats the timeout
    applyStimulus(MODE);
    repeat (3) applyStimulus(TICK);
    applyStimulus(NEXT);
    checkOutput("tb_btn_mode", 8'(mode), 8'd1);
    checkOutput("tb_btn_field", 8'(field), 8'd1);
    applyStimulus(IDLE);
    checkOutput("tb_btn_cleared", 8'(mode), 8'd1);

    // Reset with an adjust pending suppresses every pulse
    rst = 1'b1;
    applyStimulus(UP);
    rst = 1'b0;
    checkOutput("mid_rst_mode", 8'(mode), 8'd0);
    checkOutput("mid_rst_adj", 8'(adj_en), 8'd0);
    checkOutput("mid_rst_sec_ld", 8'(sec_ld), 8'd0);
    checkOutput("mid_rst_field", 8'(field), 8'd0);
    checkOutput("mid_rst_dir", 8'(adj_updown), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
